// File: rtl/cmd_uart_tx.sv
// rtl/cmd_uart_tx.sv - command byte queue feeding an 8N1 UART transmitter
//
// Purpose:
//    Queues 8-bit command bytes ({opcode[7:5], payload[4:0]}) in a small FIFO.
//    Each byte is sent on txd as 8N1 frames, LSB first. Command production
//    runs at button rate and is decoupled from the serial bit rate.
//
// Ports:
//    clk           system clock, all logic on posedge
//    reset         synchronous active-low reset
//    cmd_valid     command byte present this cycle
//    cmd_data      command byte, transmitted verbatim
//    cmd_ready     queue not full; a byte is accepted on cmd_valid && cmd_ready
//    txd           UART serial output, registered, idle high
//    tx_busy       serializer is outside IDLE
//    fifo_level    bytes waiting in the queue (excludes the byte being shifted)
//    overflow      sticky, set by cmd_valid while cmd_ready is low
//    overflow_clr  clears overflow (a same-cycle set takes priority)

module cmd_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4,
   parameter int LVL_W        = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   input  logic [7:0]       cmd_data,
   output logic             cmd_ready,
   output logic             txd,
   output logic             tx_busy,
   output logic [LVL_W-1:0] fifo_level,
   output logic             overflow,
   input  logic             overflow_clr
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [7:0]       mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             overflow_q, overflow_d;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             txd_q, txd_d;

   logic             push;
   logic             pop;
   logic             baud_last;

   // Readiness depends only on the registered level, so a pop in the same
   // cycle never makes room for a push into a full queue.
   assign cmd_ready  = (level_q != FULL_LVL);
   assign txd        = txd_q;
   assign tx_busy    = (state_q != S_IDLE);
   assign fifo_level = level_q;
   assign overflow   = overflow_q;

   always_comb begin
      push      = cmd_valid && cmd_ready;
      pop       = (state_q == S_IDLE) && (level_q != '0);
      baud_last = (baud_q == BAUD_LAST);

      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = cmd_data;
      end
      wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      overflow_d = overflow_q;
      if (cmd_valid && !cmd_ready) begin
         overflow_d = 1'b1;
      end else if (overflow_clr) begin
         overflow_d = 1'b0;
      end

      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               shift_d   = mem_q[rd_ptr_q];
               state_d   = S_START;
               baud_d    = '0;
               bit_idx_d = 3'd0;
            end
         end
         S_START: begin
            if (baud_last) begin
               state_d   = S_DATA;
               baud_d    = '0;
               bit_idx_d = 3'd0;
            end else begin
               baud_d = baud_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + CNT_W'(1);
            end
         end
         default: begin
            if (baud_last) begin
               state_d = S_IDLE;
               baud_d  = '0;
            end else begin
               baud_d = baud_q + CNT_W'(1);
            end
         end
      endcase

      // The line level is decoded from the next state and registered, so
      // txd changes on the same edge as the state and carries no glitches.
      case (state_d)
         S_IDLE:  txd_d = 1'b1;
         S_START: txd_d = 1'b0;
         S_DATA:  txd_d = shift_d[bit_idx_d];
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'h00;
         txd_q      <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         txd_q      <= txd_d;
      end
   end

   // Queue storage needs no reset: a slot is never read before it is written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_cmd_uart_tx.sv
// tb/tb_cmd_uart_tx.sv - self-checking bench for cmd_uart_tx

module tb_cmd_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int LVL_W = 3;
   localparam int FRAME = 10 * CPB;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic [7:0]       cmd_data;
   logic             cmd_ready;
   logic             txd;
   logic             tx_busy;
   logic [LVL_W-1:0] fifo_level;
   logic             overflow;
   logic             overflow_clr;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: waiting bytes, the byte on the line, and the cycle
   // position inside its frame (-1 when the line is idle).
   logic [7:0] m_q [$];
   logic [7:0] m_cur;
   int         m_pos;
   logic       m_ovf;

   cmd_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH),
      .LVL_W       (LVL_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_data    (cmd_data),
      .cmd_ready   (cmd_ready),
      .txd         (txd),
      .tx_busy     (tx_busy),
      .fifo_level  (fifo_level),
      .overflow    (overflow),
      .overflow_clr(overflow_clr)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic exp_txd();
      if (m_pos < 0)       return 1'b1;
      if (m_pos < CPB)     return 1'b0;
      if (m_pos < 9 * CPB) return m_cur[(m_pos - CPB) / CPB];
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_cur = 8'h00;
      m_pos = -1;
      m_ovf = 1'b0;
   endtask

   // Advance the model by one clock edge with the given inputs.
   task automatic model_edge(input logic v, input logic [7:0] d, input logic c, input logic r);
      bit ready;
      if (!r) begin
         model_reset();
      end else begin
         ready = (m_q.size() < DEPTH);
         if (m_pos < 0) begin
            if (m_q.size() > 0) begin
               m_cur = m_q.pop_front();
               m_pos = 0;
            end
         end else begin
            m_pos++;
            if (m_pos == FRAME) m_pos = -1;
         end
         if (v && ready) m_q.push_back(d);
         if (v && !ready) m_ovf = 1'b1;
         else if (c)      m_ovf = 1'b0;
      end
   endtask

   task automatic check_outputs();
      check_eq("txd",        32'(txd),        32'(exp_txd()));
      check_eq("tx_busy",    32'(tx_busy),    32'(m_pos >= 0));
      check_eq("cmd_ready",  32'(cmd_ready),  32'(m_q.size() < DEPTH));
      check_eq("fifo_level", 32'(fifo_level), 32'(m_q.size()));
      check_eq("overflow",   32'(overflow),   32'(m_ovf));
   endtask

   // One cycle: check what the previous edge produced, then drive this cycle.
   task automatic cyc(input logic v, input logic [7:0] d, input logic c, input logic r);
      @(negedge clk);
      check_outputs();
      cmd_valid    = v;
      cmd_data     = d;
      overflow_clr = c;
      reset        = r;
      model_edge(v, d, c, r);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   logic [7:0] burst [5];

   initial begin
      burst[0] = 8'h21; burst[1] = 8'h42; burst[2] = 8'h63;
      burst[3] = 8'h84; burst[4] = 8'hA5;

      cmd_valid    = 1'b0;
      cmd_data     = 8'h00;
      overflow_clr = 1'b0;
      reset        = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);

      // reset state, then a single frame of 8'hC5
      idle(2);
      cyc(1'b1, 8'hC5, 1'b0, 1'b1);
      idle(FRAME + 4);

      // five back-to-back pushes, a refused 8'hFF, then drain in order
      for (int i = 0; i < 5; i++) cyc(1'b1, burst[i], 1'b0, 1'b1);
      cyc(1'b1, 8'hFF, 1'b0, 1'b1);
      idle(5 * (FRAME + 1) + 4);
      cyc(1'b0, 8'h00, 1'b1, 1'b1);
      idle(2);

      // full queue in IDLE with a pop pending: refused, then accepted
      for (int i = 0; i < 5; i++) cyc(1'b1, burst[i], 1'b0, 1'b1);
      begin
         int guard;
         guard = 0;
         while (!(m_pos < 0 && m_q.size() == DEPTH) && guard < 200) begin
            idle(1);
            guard++;
         end
         check_eq("idle_full_found", 32'(guard < 200), 32'd1);
      end
      cyc(1'b1, 8'h11, 1'b0, 1'b1);
      cyc(1'b1, 8'h11, 1'b0, 1'b1);
      idle(2);

      // overflow set beats clear; clear alone then clears
      cyc(1'b1, 8'h77, 1'b1, 1'b1);
      cyc(1'b0, 8'h00, 1'b1, 1'b1);
      idle(2);
      idle(6 * (FRAME + 1));

      // reset in the middle of the data bits of 8'h0F with bytes queued
      cyc(1'b1, 8'h0F, 1'b0, 1'b1);
      cyc(1'b1, 8'h5A, 1'b0, 1'b1);
      cyc(1'b1, 8'hC3, 1'b0, 1'b1);
      idle(CPB + 2 * CPB + 1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      idle(FRAME + 5);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic v, c, r;
         v = ($urandom_range(0, 99) < 8);
         c = ($urandom_range(0, 99) < 3);
         r = ($urandom_range(0, 999) != 0);
         cyc(v, 8'($urandom_range(0, 255)), c, r);
      end
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
